wb_ctrl_seq: RTL and testbench

//  Sequential writeback controller for the LMA0 core; parametrised successor to the combinational

---
 rtl/wb_ctrl_seq_if.sv | 28 ++
 rtl/wb_ctrl_seq.sv | 149 ++++++++++++++
 tb/tb_wb_ctrl_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_ctrl_seq_if.sv
// Handshake and writeback bus between the LMA0 issue stage and the writeback controller.
interface wb_ctrl_seq_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 11
);
    logic              instr_valid;
    logic [15:0]       instr;
    logic [PC_W-1:0]   pc_in;
    logic [DATA_W-1:0] memout;
    logic              mem_rvalid;
    logic              ready;
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              pend_valid;
    logic [2:0]        pend_addr;
    logic              timeout_err;

    modport master (
        output instr_valid, instr, pc_in, memout, mem_rvalid,
        input  ready, wr_en, wr_addr, wr_data, pend_valid, pend_addr, timeout_err
    );

    modport slave (
        input  instr_valid, instr, pc_in, memout, mem_rvalid,
        output ready, wr_en, wr_addr, wr_data, pend_valid, pend_addr, timeout_err
    );
endinterface

// File: rtl/wb_ctrl_seq.sv
// Sequential writeback controller for the LMA0 core: decodes one instruction at a time and issues a
// single registered register-file write, stalling on a bounded-latency load handshake.
module wb_ctrl_seq #(
    parameter int         DATA_W   = 16,
    parameter int         PC_W     = 11,
    parameter int         TIMEOUT  = 15,
    parameter logic [2:0] LINK_REG = 3'd7,
    parameter logic [2:0] LCG_REG  = 3'd3
) (
    input logic          clk,
    input logic          rst,
    wb_ctrl_seq_if.slave bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WB} state_t;

    function automatic logic [DATA_W-1:0] sext_imm7(input logic [6:0] imm);
        logic signed [6:0] s;
        s = signed'(imm);
        return DATA_W'(s);
    endfunction

    function automatic logic [DATA_W-1:0] zext_imm7(input logic [6:0] imm);
        return DATA_W'(imm);
    endfunction

    function automatic logic [DATA_W-1:0] zext_pc(input logic [PC_W-1:0] pc);
        return DATA_W'(pc);
    endfunction

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              wr_en_q, wr_en_d;
    logic [2:0]        wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              pend_valid_q, pend_valid_d;
    logic [2:0]        pend_addr_q, pend_addr_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        op;
    logic              is_lcg, is_r, is_i, is_l, is_jal, writes;
    logic [2:0]        dest;
    logic [DATA_W-1:0] src_data;

    assign op     = bus.instr[15:12];
    assign is_lcg = (bus.instr[15:9] == 7'b0000100);
    assign is_r   = (op == 4'b0000);
    assign is_i   = (op == 4'b0001);
    assign is_l   = (op[3:2] == 2'b01);
    assign is_jal = (op[3:1] == 3'b110);
    assign writes = is_r | is_i | is_l | is_jal;

    always_comb begin
        dest = bus.instr[2:0];
        if (is_lcg)      dest = LCG_REG;
        else if (is_jal) dest = LINK_REG;
        else if (is_l)   dest = {1'b0, bus.instr[1:0]};
    end

    // Immediate forms and JAL take data from the instruction/PC; everything else uses memout as seen now.
    always_comb begin
        src_data = bus.memout;
        if (bus.instr[15:10] == 6'b000110)     src_data = sext_imm7(bus.instr[9:3]);
        else if (bus.instr[15:11] == 5'b00010) src_data = zext_imm7(bus.instr[9:3]);
        else if (is_jal)                       src_data = zext_pc(bus.pc_in);
    end

    always_comb begin
        state_d       = state_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
        timeout_err_d = 1'b0;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid && ready_q && writes) begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = dest;
                    if (is_l) begin
                        state_d = WAIT_MEM;
                        cnt_d   = '0;
                    end else begin
                        state_d   = WB;
                        wr_en_d   = 1'b1;
                        wr_addr_d = dest;
                        wr_data_d = src_data;
                    end
                end
            end
            WAIT_MEM: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Load data arriving on the expiry cycle still completes the write.
                if (bus.mem_rvalid) begin
                    state_d   = WB;
                    wr_en_d   = 1'b1;
                    wr_addr_d = pend_addr_q;
                    wr_data_d = bus.memout;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                    pend_valid_d  = 1'b0;
                end
            end
            WB: begin
                state_d      = IDLE;
                pend_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.ready       = ready_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.pend_valid  = pend_valid_q;
    assign bus.pend_addr   = pend_addr_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_wb_ctrl_seq.sv
// Bench for wb_ctrl_seq: a per-cycle expectation schedule derived from instruction semantics,
// checked on every falling edge, plus literal checks at key cycles.
module tb_wb_ctrl_seq;
    localparam int TO = 15;
    localparam int N  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    wb_ctrl_seq_if #(.DATA_W(16), .PC_W(11)) bus ();

    wb_ctrl_seq #(
        .DATA_W(16), .PC_W(11), .TIMEOUT(TO), .LINK_REG(3'd7), .LCG_REG(3'd3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit          e_rdy[N];
    bit          e_wr[N];
    logic [2:0]  e_wa[N];
    logic [15:0] e_wd[N];
    bit          e_pv[N];
    logic [2:0]  e_pa[N];
    bit          e_to[N];
    bit          e_clr[N];

    logic [2:0]  m_wa = '0;
    logic [15:0] m_wd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural meaning of one instruction: does it write, is it a load, where, and what value.
    function automatic void decode(input logic [15:0] ins, input logic [10:0] pc, input logic [15:0] mem,
                                   output bit wr, output bit isl, output logic [2:0] d, output logic [15:0] v);
        logic [6:0] imm;
        imm = ins[9:3];
        wr = 1'b1; isl = 1'b0; d = ins[2:0]; v = mem;
        casez (ins[15:12])
            4'b0000: if (ins[11:9] == 3'b100) d = 3'd3;
            4'b0001: begin
                if (ins[11:10] == 2'b10) v = {{9{imm[6]}}, imm};
                else if (ins[11] == 1'b0) v = {9'b0, imm};
            end
            4'b01??: begin isl = 1'b1; d = {1'b0, ins[1:0]}; end
            4'b110?: begin d = 3'd7; v = {5'b0, pc}; end
            default: wr = 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (cyc < N) begin
            if (e_clr[cyc]) begin m_wa = '0; m_wd = '0; end
            if (e_wr[cyc])  begin m_wa = e_wa[cyc]; m_wd = e_wd[cyc]; end
            chk("ready", bus.ready, e_rdy[cyc]);
            chk("wr_en", bus.wr_en, e_wr[cyc]);
            chk("wr_addr", bus.wr_addr, m_wa);
            chk("wr_data", bus.wr_data, m_wd);
            chk("pend_valid", bus.pend_valid, e_pv[cyc]);
            if (e_pv[cyc]) chk("pend_addr", bus.pend_addr, e_pa[cyc]);
            chk("timeout_err", bus.timeout_err, e_to[cyc]);
        end
    end

    // rv_k: cycles after accept at which mem_rvalid is driven (0 = never).
    task automatic issue(input logic [15:0] ins, input logic [10:0] pc, input logic [15:0] mem,
                         input int rv_k, input logic [15:0] ld, input bit hold,
                         input bit lit, input logic [2:0] lit_wa, input logic [15:0] lit_wd);
        int c, last;
        bit wr, isl;
        logic [2:0] d;
        logic [15:0] v;
        c = cyc;
        decode(ins, pc, mem, wr, isl, d, v);
        if (wr) begin
            if (!isl)         last = c + 1;
            else if (rv_k > 0) last = c + rv_k + 1;
            else              last = c + TO;
            for (int t = c + 1; t <= last; t++) begin
                e_rdy[t] = 1'b0; e_pv[t] = 1'b1; e_pa[t] = d;
            end
            if (isl && rv_k == 0) e_to[c + TO + 1] = 1'b1;
            else begin
                e_wr[last] = 1'b1; e_wa[last] = d; e_wd[last] = isl ? ld : v;
            end
        end
        bus.instr_valid = 1'b1; bus.instr = ins; bus.pc_in = pc; bus.memout = mem;
        step();
        if (hold) bus.instr = 16'h1BF8;
        else bus.instr_valid = 1'b0;
        bus.memout = 16'h1234;
        if (!wr) begin
            if (lit) begin
                chk("nowr_ready", bus.ready, 1);
                chk("nowr_wr_en", bus.wr_en, 0);
            end
            return;
        end
        if (isl && rv_k > 0) begin
            while (cyc < c + rv_k) step();
            bus.mem_rvalid = 1'b1; bus.memout = ld;
            step();
            bus.mem_rvalid = 1'b0; bus.memout = 16'h1234;
        end else if (isl) begin
            while (cyc < c + TO + 1) step();
        end
        if (lit) begin
            if (isl && rv_k == 0) begin
                chk("lit_timeout_err", bus.timeout_err, 1);
                chk("lit_timeout_ready", bus.ready, 1);
                chk("lit_timeout_wr_en", bus.wr_en, 0);
            end else begin
                chk("lit_wr_en", bus.wr_en, 1);
                chk("lit_wr_addr", bus.wr_addr, lit_wa);
                chk("lit_wr_data", bus.wr_data, lit_wd);
            end
        end
        step();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        int c;
        for (int t = 0; t < N; t++) begin
            e_rdy[t] = 1'b1; e_wr[t] = 1'b0; e_wa[t] = '0; e_wd[t] = '0;
            e_pv[t] = 1'b0; e_pa[t] = '0; e_to[t] = 1'b0; e_clr[t] = 1'b0;
        end
        bus.instr_valid = 1'b0; bus.instr = '0; bus.pc_in = '0; bus.memout = '0; bus.mem_rvalid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        issue(16'h1BF8, 11'h000, 16'h0000, 0, 16'h0, 0, 1, 3'd0, 16'hFFFF);
        issue(16'h12AD, 11'h000, 16'h9999, 0, 16'h0, 0, 1, 3'd5, 16'h0055);
        issue(16'h0006, 11'h000, 16'hCAFE, 0, 16'h0, 0, 1, 3'd6, 16'hCAFE);
        issue(16'hC000, 11'h5A3, 16'h7777, 0, 16'h0, 0, 1, 3'd7, 16'h05A3);
        issue(16'hE000, 11'h123, 16'h0000, 0, 16'h0, 0, 1, 3'd0, 16'h0000);
        issue(16'h8005, 11'h010, 16'h4444, 0, 16'h0, 0, 0, 3'd0, 16'h0000);
        issue(16'h4002, 11'h000, 16'h1111, 3, 16'hBEEF, 0, 1, 3'd2, 16'hBEEF);

        bus.mem_rvalid = 1'b1; bus.memout = 16'hDEAD;
        step(); step();
        bus.mem_rvalid = 1'b0;
        step();

        c = cyc;
        for (int t = c + 1; t <= c + TO; t++) begin
            e_rdy[t] = 1'b0; e_pv[t] = 1'b1; e_pa[t] = 3'd1;
        end
        e_to[c + TO + 1] = 1'b1;
        bus.instr_valid = 1'b1; bus.instr = 16'h4001; bus.memout = 16'h2222;
        step();
        bus.instr_valid = 1'b0;
        step(); step();
        #2;
        rst = 1'b1;
        for (int t = cyc; t < N; t++) begin
            e_rdy[t] = 1'b1; e_pv[t] = 1'b0; e_wr[t] = 1'b0; e_to[t] = 1'b0;
        end
        e_clr[cyc] = 1'b1;
        #1;
        chk("rst_ready", bus.ready, 1);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_pend_valid", bus.pend_valid, 0);
        chk("rst_pend_addr", bus.pend_addr, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        step(); step();
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.memout = 16'hABCD;
        step();
        bus.mem_rvalid = 1'b0;
        repeat (TO + 2) step();

        issue(16'h4003, 11'h000, 16'h0000, 0, 16'h0, 0, 1, 3'd0, 16'h0000);
        issue(16'h7001, 11'h000, 16'h0000, TO, 16'h0F0F, 0, 1, 3'd1, 16'h0F0F);
        issue(16'h0800, 11'h000, 16'h5A5A, 0, 16'h0, 1, 1, 3'd3, 16'h5A5A);
        issue(16'h5C03, 11'h000, 16'h3333, 1, 16'h8001, 0, 1, 3'd3, 16'h8001);
        issue(16'h19FC, 11'h000, 16'h6666, 0, 16'h0, 0, 1, 3'd4, 16'h003F);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
